scan_mux_nto1: RTL
==================

// Module: scan_mux_nto1
// PURPOSE
//   Registered, parametrised N:1 channel multiplexer; next generation of the 8:1 mux.
//   Two modes:
//   - Manual: picks the channel on Select.
//   - Scan: round-robins over the channels enabled in Mask.
//   Output uses a valid/ready handshake toward downstream logic (display/ALU feed).
// PARAMETERS
//   WIDTH   8  bits per channel
//   NUM_CH  8  number of input channels (>=2)
//   SEL_W   3  select width; 2**SEL_W >= NUM_CH
// PORTS
//   Clk     in   1             system clock, rising edge
//   Reset   in   1             synchronous, active-high
//   In      in   NUM_CH*WIDTH  channel k = In[k*WIDTH +: WIDTH]
//   Mode    in   1             0 = manual, 1 = scan
//   Select  in   SEL_W         manual-mode channel index
//   Mask    in   NUM_CH        scan-mode channel enables, bit k = channel k
//   Ready   in   1             downstream accepts Out this cycle
//   Out     out  WIDTH         registered selected data
//   OutSel  out  SEL_W         channel index that produced Out
//   Valid   out  1             Out/OutSel hold a sample
// BEHAVIOUR
//   Reset (sync, checked at Clk edge)
//     - Out=0, OutSel=0, Valid=0, Ptr=0, state=IDLE.
//     - Overrides everything, including mid-scan and stalled output.
//   Slot free when (!Valid || Ready). Load happens only when the slot is free. Latency = 1 cycle.
//   Hold
//     - Valid && !Ready: Out, OutSel, Valid stay stable.
//     - Select, Mask and Mode changes are ignored until the slot frees.
//   States
//     IDLE
//       - Valid=0.
//       - Mode=0 -> MAN.
//       - Mode=1 && Mask!=0 -> SCAN.
//     MAN, on free slot
//       - Select < NUM_CH: Out<=In[Select], OutSel<=Select, Valid<=1.
//       - Select >= NUM_CH: Valid<=0, Out unchanged.
//       - Mode=1 -> SCAN (if Mask!=0) else IDLE. Transition evaluated on the same free-slot edge, no load.
//     SCAN, on free slot
//       - c = first k with Mask[k]=1, searching from Ptr upward, wrapping NUM_CH-1 -> 0 (Ptr itself eligible).
//       - Out<=In[c], OutSel<=c, Valid<=1, Ptr<=(c+1) mod NUM_CH.
//       - Single enabled channel reloads the same channel every free cycle.
//       - Mask==0: Valid<=0, go IDLE.
//       - Mode=0: Valid<=0, go MAN; Ptr retained.
//   Mask changes take effect at the next search. A held sample is never altered.
//   In is sampled only at the load edge; later In changes do not affect a held Out.
//   Ptr arithmetic is mod NUM_CH (not 2**SEL_W) for non-power-of-2 NUM_CH.
// TESTING (WIDTH=8, NUM_CH=8 unless noted; channel k drives 8'hA0+k)
//   1. Manual sweep: Mode=0, Ready=1, Select=0..7, one per cycle
//      -> Out=A0..A7, each 1 cycle after Select; OutSel matches; Valid=1.
//   2. Backpressure: manual, Select=3, Ready=0 for 3 cycles, Select->6
//      -> Out=A3 held, Valid=1. Ready=1 -> next cycle Out=A6.
//   3. Scan: Mode=1, Mask=8'b1010_0101, Ready=1 -> OutSel sequence 0,2,5,7,0,2 with wrap.
//      Ready toggling 1,0,1 -> no channel skipped.
//   4. Mask edge: mid-scan Mask->8'b0001_0000 -> OutSel 4,4,4.
//      Mask->0 -> Valid=0 next free edge, state IDLE.
//   5. Reset mid-scan with Valid=1, Ready=0 -> next edge Out=0, Valid=0.
//      Release -> scan restarts at lowest enabled channel >= 0.
//   6. NUM_CH=6, SEL_W=3:
//      - Select=7 -> Valid=0.
//      - Scan with Mask=6'b100001 -> OutSel 0,5,0 (wrap at 6).

Source files
------------

// File: rtl/scan_mux_nto1.sv
// rtl/scan_mux_nto1.sv - registered N:1 channel mux with manual select and masked round-robin scan
// Output register is a single valid/ready slot; a new sample loads only when the slot is free.
module scan_mux_nto1 #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_CH*WIDTH-1:0] In,
  input  logic                    Mode,
  input  logic [SEL_W-1:0]        Select,
  input  logic [NUM_CH-1:0]       Mask,
  input  logic                    Ready,
  output logic [WIDTH-1:0]        Out,
  output logic [SEL_W-1:0]        OutSel,
  output logic                    Valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  ptr_nxt;
  logic [SEL_W-1:0]  pick;
  logic [SEL_W-1:0]  load_sel;
  logic [SEL_W:0]    sum;
  logic [2*NUM_CH-1:0] rot;
  logic [WIDTH-1:0]  load_data;
  logic              hit;
  logic              free;
  logic              sel_ok;
  logic              load;
  logic              drop;
  logic              ptr_load;

  assign free   = !Valid || Ready;
  assign sel_ok = ({1'b0, Select} < (SEL_W+1)'(NUM_CH));

  // Rotate the mask so bit 0 is the channel at ptr; the lowest set bit is the next grant.
  always_comb begin
    rot  = {Mask, Mask} >> ptr;
    hit  = 1'b0;
    pick = '0;
    sum  = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (rot[j]) begin
        hit = 1'b1;
        sum = {1'b0, ptr} + (SEL_W+1)'(j);
        if (sum >= (SEL_W+1)'(NUM_CH)) begin
          sum = sum - (SEL_W+1)'(NUM_CH);
        end
        pick = sum[SEL_W-1:0];
      end
    end
  end

  assign ptr_nxt = (pick == SEL_W'(NUM_CH - 1)) ? '0 : pick + 1'b1;

  always_comb begin
    load_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (load_sel == SEL_W'(k)) begin
        load_data = In[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      ptr    <= '0;
      Out    <= '0;
      OutSel <= '0;
      Valid  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        Out    <= load_data;
        OutSel <= load_sel;
        Valid  <= 1'b1;
      end else if (drop) begin
        Valid <= 1'b0;
      end
      if (ptr_load) begin
        ptr <= ptr_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!Mode) begin
          state_nxt = MAN;
        end else if (|Mask) begin
          state_nxt = SCAN;
        end
      end
      MAN: begin
        if (free && Mode) begin
          state_nxt = (|Mask) ? SCAN : IDLE;
        end
      end
      SCAN: begin
        if (free) begin
          if (!Mode) begin
            state_nxt = MAN;
          end else if (!hit) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A mode switch consumes its free-slot edge without loading, so a taken sample is never re-presented.
  always_comb begin
    load     = 1'b0;
    drop     = 1'b0;
    ptr_load = 1'b0;
    load_sel = Select;
    case (state)
      IDLE: drop = 1'b1;
      MAN: begin
        if (free) begin
          if (Mode || !sel_ok) begin
            drop = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      SCAN: begin
        load_sel = pick;
        if (free) begin
          if (!Mode || !hit) begin
            drop = 1'b1;
          end else begin
            load     = 1'b1;
            ptr_load = 1'b1;
          end
        end
      end
      default: drop = 1'b1;
    endcase
  end

endmodule
